alu_issue: RTL and testbench

//  Issue/write-back controller that drives the shared combinational ALU.
//  - Accepts 16-bit instruction words over a valid/ready handshake and decodes them.
//  - Reads operands from an internal 16-entry register file.
//  - Presents registered alu_a/alu_b/alu_op to the ALU, captures alu_out and writes rd.

---
 rtl/alu_issue.sv | 197 +++++++++++++++++++
 tb/tb_alu_issue.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue
// Issue/write-back controller for a shared combinational ALU.
// Instructions arrive over a valid/ready handshake and are decoded. Operands
// come from an internal 16-entry register file (r0 always reads as zero). The
// block presents registered operands/op to the ALU and captures alu_out. The
// captured result is written back to rd and reported on the res_* pulse.
//
// Configuration macro: MUL_EN
//   defined   : MUL (op 7) is held for MUL_LAT cycles, then written back.
//   undefined : an accepted MUL pulses illegal in the cycle after accept.
//               It writes nothing and returns to IDLE after one EXEC cycle.
//
// Parameters
//   DSIZE    datapath width (ALU operand width)
//   MUL_LAT  cycles a MUL is held before capture (>= 1)
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   instr_valid/ready/data        instruction handshake
//                                 data = {opc, rd, rs1, rs2/imm4}
//   alu_a, alu_b, alu_op          registered ALU operands and op code
//   alu_out                       ALU result (combinational from alu_a/b/op)
//   res_valid, res_rd, res_data   one-cycle write-back report
//   illegal                       one-cycle pulse on a rejected MUL
//   dbg_addr, dbg_data            combinational register-file debug read
// -----------------------------------------------------------------------------
module alu_issue #(
  parameter int DSIZE   = 16,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [15:0]      instr_data,
  output logic [DSIZE-1:0] alu_a,
  output logic [DSIZE-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [DSIZE-1:0] alu_out,
  output logic             res_valid,
  output logic [3:0]       res_rd,
  output logic [DSIZE-1:0] res_data,
  output logic             illegal,
  input  logic [3:0]       dbg_addr,
  output logic [DSIZE-1:0] dbg_data
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       rd_q, rd_d;
  logic [DSIZE-1:0] alu_a_q, alu_a_d;
  logic [DSIZE-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             res_valid_q, res_valid_d;
  logic [3:0]       res_rd_q, res_rd_d;
  logic [DSIZE-1:0] res_data_q, res_data_d;
  logic             illegal_q, illegal_d;
  logic [DSIZE-1:0] regs_q [16];
  logic [DSIZE-1:0] regs_d [16];

  logic [3:0] opc_s, rd_s, rs1_s, rs2_s;

  assign opc_s = instr_data[15:12];
  assign rd_s  = instr_data[11:8];
  assign rs1_s = instr_data[7:4];
  assign rs2_s = instr_data[3:0];

  // Next-state logic for the issue FSM, operand latches, write-back and regfile.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    res_valid_d = 1'b0;
    res_rd_d    = res_rd_q;
    res_data_d  = res_data_q;
    illegal_d   = 1'b0;
    regs_d      = regs_q;

    case (state_q)
      S_IDLE: begin
        // instr_ready is high throughout IDLE, so valid alone means accept.
        if (instr_valid) begin
          // regs_q[0] is never written, so indexing it yields zero for r0.
          alu_a_d = regs_q[rs1_s];
          if (opc_s[3]) begin
            alu_b_d = {{(DSIZE-4){1'b0}}, rs2_s};
          end else begin
            alu_b_d = regs_q[rs2_s];
          end
          alu_op_d = opc_s[2:0];
          rd_d     = rd_s;
          state_d  = S_EXEC;
`ifdef MUL_EN
          if (opc_s[2:0] == OP_MUL) begin
            cnt_d = CW'(MUL_LAT - 1);
          end else begin
            cnt_d = {CW{1'b0}};
          end
`else
          cnt_d     = {CW{1'b0}};
          illegal_d = (opc_s[2:0] == OP_MUL);
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        if (cnt_q != {CW{1'b0}}) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = S_IDLE;
`ifdef MUL_EN
          res_valid_d = 1'b1;
`else
          // A rejected MUL just drains through EXEC without writing.
          res_valid_d = (alu_op_q != OP_MUL);
`endif
          if (res_valid_d) begin
            res_rd_d   = rd_q;
            res_data_d = alu_out;
            if (rd_q != 4'd0) begin
              regs_d[rd_q] = alu_out;
            end else begin
              regs_d[0] = {DSIZE{1'b0}};
            end
          end else begin
            res_rd_d = res_rd_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // State, operand, result and register-file flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      cnt_q       <= {CW{1'b0}};
      rd_q        <= 4'd0;
      alu_a_q     <= {DSIZE{1'b0}};
      alu_b_q     <= {DSIZE{1'b0}};
      alu_op_q    <= OP_ADD;
      res_valid_q <= 1'b0;
      res_rd_q    <= 4'd0;
      res_data_q  <= {DSIZE{1'b0}};
      illegal_q   <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= {DSIZE{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      res_valid_q <= res_valid_d;
      res_rd_q    <= res_rd_d;
      res_data_q  <= res_data_d;
      illegal_q   <= illegal_d;
      regs_q      <= regs_d;
    end
  end

  assign instr_ready = ready_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign res_valid   = res_valid_q;
  assign res_rd      = res_rd_q;
  assign res_data    = res_data_q;
  assign illegal     = illegal_q;
  assign dbg_data    = (dbg_addr == 4'd0) ? {DSIZE{1'b0}} : regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

  localparam int DSIZE   = 16;
  localparam int MUL_LAT = 2;

  logic             clk;
  logic             rst_n;
  logic             instr_valid;
  logic             instr_ready;
  logic [15:0]      instr_data;
  logic [DSIZE-1:0] alu_a;
  logic [DSIZE-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [DSIZE-1:0] alu_out;
  logic             res_valid;
  logic [3:0]       res_rd;
  logic [DSIZE-1:0] res_data;
  logic             illegal;
  logic [3:0]       dbg_addr;
  logic [DSIZE-1:0] dbg_data;

  alu_issue #(.DSIZE(DSIZE), .MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_data (instr_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_out    (alu_out),
    .res_valid  (res_valid),
    .res_rd     (res_rd),
    .res_data   (res_data),
    .illegal    (illegal),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  // Shared combinational ALU the controller drives.
  always_comb begin
    case (alu_op)
      3'd0: alu_out = alu_a + alu_b;
      3'd1: alu_out = alu_a - alu_b;
      3'd2: alu_out = alu_a & alu_b;
      3'd3: alu_out = alu_a ^ alu_b;
      3'd4: alu_out = alu_a << alu_b[3:0];
      3'd5: alu_out = alu_a >> alu_b[3:0];
      3'd6: alu_out = {15'd0, (alu_a < alu_b)};
      3'd7: alu_out = alu_a * alu_b;
      default: alu_out = 16'd0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_ill;
    logic [3:0]  rd;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_regs [16];
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  // Reference ALU semantics with plain integer arithmetic, truncated to 16 bits.
  function automatic logic [15:0] ref_op(input int op, input longint a, input longint b);
    longint r;
    int     sh;
    sh = int'(b % 16);
    case (op)
      0: r = a + b;
      1: r = a - b + 65536;
      2: r = a & b;
      3: r = a ^ b;
      4: r = a * (2 ** sh);
      5: r = a / (2 ** sh);
      6: r = (a < b) ? 1 : 0;
      7: r = a * b;
      default: r = 0;
    endcase
    return 16'(r % 65536);
  endfunction

  // Monitor: every res_valid/illegal pulse must match the oldest expectation.
  exp_t e;
  always @(negedge clk) begin
    if (rst_n && (res_valid || illegal)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, res_valid, illegal}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {30'd0, res_valid, illegal}, e.is_ill ? 32'd1 : 32'd2);
        chk("pulse_cycle", cyc, e.cyc);
        if (!e.is_ill) begin
          chk("res_rd", res_rd, e.rd);
          chk("res_data", res_data, e.data);
        end
      end
    end
  end

  task automatic dbg_rd(input int addr, output logic [15:0] v);
    dbg_addr = 4'(addr);
    #1;
    v = dbg_data;
  endtask

  // Call only while no instruction is in flight.
  task automatic check_regs();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) begin
      dbg_rd(i, v);
      chk($sformatf("dbg_r%0d", i), v, m_regs[i]);
    end
  endtask

  task automatic check_reset_state();
    logic [15:0] v;
    chk("rst_ready", instr_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_res_rd", res_rd, 0);
    chk("rst_res_data", res_data, 0);
    for (int i = 0; i < 16; i++) begin
      dbg_rd(i, v);
      chk($sformatf("rst_dbg_r%0d", i), v, 0);
    end
  endtask

  // Issue one instruction. Entered and left at a negedge with instr_valid=0.
  // With abort=1 it returns during EXEC without recording an expectation.
  task automatic issue(input logic [15:0] instr, input bit abort);
    int          w, op, busy, lat, acc;
    bit          ill;
    logic [15:0] a, b, r;
    w = 0;
    while (!instr_ready) begin
      instr_valid = 1'($urandom % 2);
      instr_data  = 16'($urandom);
      @(negedge clk);
      w++;
      if (w > 40) begin
        chk("ready_timeout", 0, 1);
        finish_run();
      end
    end
    instr_valid = 1'b1;
    instr_data  = instr;
    acc = cyc + 1;
    op  = int'(instr[14:12]);
    a   = m_regs[instr[7:4]];
    b   = instr[15] ? {12'd0, instr[3:0]} : m_regs[instr[3:0]];
    r   = ref_op(op, a, b);
`ifdef MUL_EN
    ill = 1'b0;
    lat = (op == 7) ? MUL_LAT : 1;
`else
    ill = (op == 7);
    lat = 1;
`endif
    busy = lat;
    if (!abort) begin
      sb.push_back('{is_ill: ill, rd: instr[11:8], data: r, cyc: ill ? acc : acc + lat});
      if (!ill && instr[11:8] != 4'd0) m_regs[instr[11:8]] = r;
    end
    @(negedge clk);
    instr_valid = 1'($urandom % 2);
    instr_data  = 16'($urandom);
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, b);
    chk("alu_op", alu_op, op);
    chk("ready_low", instr_ready, 0);
    if (abort) begin
      instr_valid = 1'b0;
      return;
    end
    w = 1;
    @(negedge clk);
    while (!instr_ready && w < 40) begin
      w++;
      instr_valid = 1'($urandom % 2);
      instr_data  = 16'($urandom);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("busy_cycles", w, busy);
  endtask

  logic [15:0] v;

  initial begin
    rst_n       = 1'b1;
    instr_valid = 1'b0;
    instr_data  = 16'd0;
    dbg_addr    = 4'd0;
    for (int i = 0; i < 16; i++) m_regs[i] = 16'd0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state();
    @(negedge clk);

    // ADDI r1,r0,#5 then dependent ADD r2,r1,r1, back to back.
    issue(16'h8105, 1'b0);
    issue(16'h0211, 1'b0);
    dbg_rd(1, v); chk("r1_is_5", v, 16'd5);
    dbg_rd(2, v); chk("r2_is_10", v, 16'd10);
    @(negedge clk);

    // SUBI r3,r0,#1 wraps; SLLI r4,r1,#3.
    issue(16'h9301, 1'b0);
    issue(16'hC413, 1'b0);
    dbg_rd(3, v); chk("r3_is_ffff", v, 16'hFFFF);
    dbg_rd(4, v); chk("r4_is_40", v, 16'd40);
    @(negedge clk);

    // MUL r5,r2,r1.
    issue(16'h7521, 1'b0);
    dbg_rd(5, v);
`ifdef MUL_EN
    chk("r5_mul_50", v, 16'd50);
`else
    chk("r5_unchanged", v, 16'd0);
`endif
    @(negedge clk);

    // ADD r0,r1,r1: pulse with res_rd=0, r0 stays 0.
    issue(16'h0011, 1'b0);
    dbg_rd(0, v); chk("r0_stays_0", v, 16'd0);
    check_regs();
    @(negedge clk);

    // Reset during EXEC of ADDI r6,r0,#7 drops the write.
    issue(16'h8607, 1'b1);
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) m_regs[i] = 16'd0;
    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    dbg_rd(6, v); chk("r6_after_reset", v, 16'd0);
    @(negedge clk);
    issue(16'h8607, 1'b0);
    dbg_rd(6, v); chk("r6_is_7", v, 16'd7);
    @(negedge clk);

    // Seed a few registers, then random traffic with random gaps.
    for (int i = 1; i < 16; i++) issue({4'h8, 4'(i), 4'd0, 4'($urandom)}, 1'b0);
    for (int n = 0; n < 300; n++) begin
      issue(16'($urandom), 1'b0);
      if ($urandom % 4 == 0) repeat ($urandom % 3 + 1) @(negedge clk);
      if (n % 75 == 74) begin
        check_regs();
        @(negedge clk);
      end
    end
    check_regs();
    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    finish_run();
  end

  initial begin
    #200000;
    chk("global_timeout", 0, 1);
    finish_run();
  end

endmodule
